sseg_scan_ctrl: RTL
===================

SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, meaning the number of multiplexed digits (legal range 1..16).
REQ-002 SHALL have parameter TICK_DIV, default 65536, meaning clk cycles per digit slot (legal range at least 2).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, meaning full scan frames per blink half-period.
REQ-004 SHALL have parameter AN_ACTIVE_LOW, default 1, meaning anode polarity (1 = low selects a digit).
REQ-005 SHALL have port clk, input, 1 bit, system clock.
REQ-006 SHALL have port rst, input, 1 bit, synchronous active-low reset.
REQ-007 SHALL have port digit_data, input, 4*NUM_DIGITS bits, hex nibble per digit; digit i is bits [4i+3:4i].
REQ-008 SHALL have port digit_en, input, NUM_DIGITS bits, 0 = digit blanked.
REQ-009 SHALL have port dp_in, input, NUM_DIGITS bits, decimal point per digit, 1 = lit.
REQ-010 SHALL have port blink_mask, input, NUM_DIGITS bits, 1 = digit blinks.
REQ-011 SHALL have port load, input, 1 bit, single-cycle request to capture all of digit_data, digit_en, dp_in and blink_mask.
REQ-012 SHALL have port sseg, output, 7 bits [0:6] = segments a..g, active-low.
REQ-013 SHALL have port dp, output, 1 bit, active-low decimal point.
REQ-014 SHALL have port an, output, NUM_DIGITS bits, digit select with polarity set by AN_ACTIVE_LOW.
REQ-015 SHALL have port frame_done, output, 1 bit, one-cycle pulse when the last digit slot ends.

Function
REQ-016 SHALL count a prescaler 0..TICK_DIV-1 and wrap; a tick occurs on the cycle where prescaler = TICK_DIV-1.
REQ-017 SHALL advance the digit index on each tick, wrapping from NUM_DIGITS-1 to 0.
REQ-018 SHALL pulse frame_done for exactly the tick cycle on which the index wraps.
REQ-019 SHALL drive all anodes inactive for exactly one clk after each tick (anti-ghosting blank), then select the new index.
REQ-020 SHALL register all outputs; sseg and dp SHALL change only in the same cycle as an.
REQ-021 SHALL display from a shadow register set, not directly from the inputs.
REQ-022 SHALL, on load, set a pending flag; the shadow set SHALL update on the frame_done cycle while pending, then clear pending (tear-free update).
REQ-023 SHALL let the latest data win when load repeats while pending, and SHALL copy the inputs present on the frame_done cycle.
REQ-024 SHALL take the update immediately when load coincides with frame_done, leaving pending clear.
REQ-025 SHALL decode nibbles 0-F to the standard hex glyphs (A,b,C,d,E,F).
REQ-026 SHALL, for a digit with digit_en = 0, drive sseg = 7'b1111111 and dp = 1 while still cycling its anode.

Reset
REQ-027 SHALL, while rst = 0, hold prescaler = 0, index = 0, pending = 0, all anodes inactive, sseg = 7'b1111111, dp = 1 and frame_done = 0.
REQ-028 SHALL clear the shadow set to all-zero with digit_en = 0 on reset, so the display is blank until the first load.
REQ-029 SHALL, on reset asserted mid-frame, abandon the frame and any pending load; the first digit slot after release is index 0.

Configuration
REQ-030 SHALL compile blink support only when macro SSEG_SCAN_BLINK_EN is defined.
REQ-031 SHALL, with SSEG_SCAN_BLINK_EN defined, count frames 0..BLINK_FRAMES-1 and toggle a blink phase (reset 0 = visible) at each wrap.
REQ-032 SHALL, during the invisible blink phase, blank digits whose shadow blink_mask bit is 1, as in REQ-026.
REQ-033 SHALL, without SSEG_SCAN_BLINK_EN, ignore blink_mask and contain no blink logic.

Structure
REQ-034 SHALL place the 16 glyph constants and the blank pattern constant in shared package sseg_pkg.
REQ-035 SHALL instantiate combinational sub-module sseg_hex_decoder (nibble in, 7-bit active-low glyph out).

Verification (NUM_DIGITS = 4, TICK_DIV = 4, BLINK_FRAMES = 2, AN_ACTIVE_LOW = 1)
REQ-036 SHALL check: hold reset, release, load 16'h1A3F with all digits enabled -> after the next frame_done, an walks 1110, 1101, 1011, 0111, each selection preceded by one 1111 cycle, and sseg shows F, 3, A, 1.
REQ-037 SHALL check: load during slot 2, then a second load with different data before frame_done -> the rest of the frame shows the old digits, and the second data appears from slot 0.
REQ-038 SHALL check: digit_en = 4'b1011, dp_in = 4'b0001 -> in digit 2's slot sseg = 1111111 and dp = 1; in digit 0's slot dp = 0.
REQ-039 SHALL check: with SSEG_SCAN_BLINK_EN, blink_mask = 4'b0001 -> digit 0 is blank on alternate 2-frame periods; other digits are never blanked.
REQ-040 SHALL check: rst pulsed low for 1 cycle mid-slot-3 with a load pending -> outputs return to reset values, the pending load is discarded, and the display stays blank.
REQ-041 SHALL check: load asserted on the frame_done cycle -> the new data is shown in the very next slot 0.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared seven-segment glyph table for the scan controller.
// Segment order is a..g, active-low.
package sseg_pkg;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b1100000;
  localparam seg_t SEG_C     = 7'b0110001;
  localparam seg_t SEG_D     = 7'b1000010;
  localparam seg_t SEG_E     = 7'b0110000;
  localparam seg_t SEG_F     = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational nibble to hex glyph decoder.
// Output is active-low, segments a..g.
module sseg_hex_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with tear-free shadow load.
// Digit blinking is built only when SSEG_SCAN_BLINK_EN is defined.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int TICK_DIV      = 65536,
  parameter int BLINK_FRAMES  = 64,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    load,
  output logic [0:6]              sseg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam int ND = NUM_DIGITS;

  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(ND - 1);
  localparam logic [ND-1:0] ONE    = ND'(1);
  localparam logic [ND-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {ND{1'b1}} : '0;

  logic [PW-1:0]   presc_q, presc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            pend_q, pend_d;
  logic            fd_q, fd_d;
  logic [ND-1:0]   an_q, an_d;
  seg_t            sseg_q, sseg_d;
  logic            dp_q, dp_d;
  logic [4*ND-1:0] sh_data_q, sh_data_d;
  logic [ND-1:0]   sh_en_q, sh_en_d;
  logic [ND-1:0]   sh_dp_q, sh_dp_d;

  logic       tick, wrap, upd, vis;
  logic [3:0] nib;
  seg_t       glyph;

  assign tick = (presc_q == P_LAST);
  assign wrap = tick && (idx_q == I_LAST);
  assign upd  = wrap && (pend_q || load);
  assign nib  = sh_data_q[{idx_q, 2'b00} +: 4];

  sseg_hex_decoder u_dec (
    .nib_i (nib),
    .seg_o (glyph)
  );

`ifdef SSEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] F_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;
  logic [ND-1:0] sh_blk_q, sh_blk_d;

  always_comb begin
    fcnt_d   = fcnt_q;
    phase_d  = phase_q;
    sh_blk_d = upd ? blink_mask : sh_blk_q;
    if (wrap) begin
      fcnt_d = (fcnt_q == F_LAST) ? '0 : fcnt_q + 1'b1;
      if (fcnt_q == F_LAST) phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fcnt_q   <= '0;
      phase_q  <= 1'b0;
      sh_blk_q <= '0;
    end else begin
      fcnt_q   <= fcnt_d;
      phase_q  <= phase_d;
      sh_blk_q <= sh_blk_d;
    end
  end

  assign vis = sh_en_q[idx_q] && !(phase_q && sh_blk_q[idx_q]);
`else
  localparam int unused_bf = BLINK_FRAMES;
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign vis = sh_en_q[idx_q];
`endif

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
    // registered pulse lines up with the tick cycle of the last slot
    fd_d = (presc_d == P_LAST) && (idx_d == I_LAST);

    pend_d    = pend_q;
    sh_data_d = sh_data_q;
    sh_en_d   = sh_en_q;
    sh_dp_d   = sh_dp_q;
    if (upd) begin
      pend_d    = 1'b0;
      sh_data_d = digit_data;
      sh_en_d   = digit_en;
      sh_dp_d   = dp_in;
    end else if (load) begin
      pend_d = 1'b1;
    end

    an_d   = AN_OFF;
    sseg_d = SEG_BLANK;
    dp_d   = 1'b1;
    if (!tick) begin
      an_d = (ONE << idx_q) ^ AN_OFF;
      if (vis) begin
        sseg_d = glyph;
        dp_d   = ~sh_dp_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q   <= '0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      fd_q      <= 1'b0;
      an_q      <= AN_OFF;
      sseg_q    <= SEG_BLANK;
      dp_q      <= 1'b1;
      sh_data_q <= '0;
      sh_en_q   <= '0;
      sh_dp_q   <= '0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      fd_q      <= fd_d;
      an_q      <= an_d;
      sseg_q    <= sseg_d;
      dp_q      <= dp_d;
      sh_data_q <= sh_data_d;
      sh_en_q   <= sh_en_d;
      sh_dp_q   <= sh_dp_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule
